// File: rtl/wall_generator_pkg.sv
// Shared constants, state encoding and LFSR step function for the scrolling wall.
package wall_generator_pkg;

  localparam logic [7:0] SCREEN_W   = 8'd160;  // spawn x of the wall's left edge
  localparam logic [7:0] WALL_W     = 8'd16;   // wall width in pixels
  localparam logic [7:0] GAP_H      = 8'd40;   // vertical opening height
  localparam logic [7:0] Y_MIN      = 8'd8;    // smallest gap top
  localparam logic [7:0] BIRD_X     = 8'd32;   // bird's fixed left x
  localparam logic [7:0] TOPY_RESET = Y_MIN + 8'd32;

  // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCROLL  = 2'd1,
    ST_RESPAWN = 2'd2
  } state_t;

  // One left shift with the XOR of the tapped bits fed into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wall_generator_lfsr8.sv
// Free-running 8-bit maximal-length LFSR; a non-zero seed keeps it out of the all-zero lock-up.
module lfsr8
  import wall_generator_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  output logic [7:0] q
);

  // Advance every clock regardless of what the wall FSM is doing.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q <= LFSR_SEED;
    else         q <= lfsr_step(q);
  end

endmodule

// File: rtl/wall_generator.sv
// Scrolling wall: moves left per frame tick, respawns at the right edge with a random gap,
// and pulses 'passed' once when the wall's right edge clears the bird column.
module wall_generator
  import wall_generator_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       restart,
  input  logic [1:0] speed,
  output logic [7:0] wall_xleft,
  output logic [7:0] wall_xright,
  output logic [7:0] wall_topy,
  output logic [7:0] wall_bottomy,
  output logic       wall_valid,
  output logic       passed
);

  state_t     state, state_next;
  logic [7:0] xleft_next, topy_next, bottomy_next;
  logic       valid_next, passed_next;
  logic [7:0] step;
  logic [7:0] xright_next;
  logic [7:0] lfsr;
  logic [1:0] lfsr_unused;

  lfsr8 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .q      (lfsr)
  );

  // Only the low six bits pick the gap height.
  assign lfsr_unused = lfsr[7:6];

  assign step        = {6'd0, speed} + 8'd1;
  assign wall_xright = wall_xleft + (WALL_W - 8'd1);
  assign xright_next = xleft_next + (WALL_W - 8'd1);

  // Next-state and datapath update; restart overrides everything except the LFSR.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    xleft_next   = wall_xleft;
    topy_next    = wall_topy;
    bottomy_next = wall_bottomy;
    passed_next  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (frame_tick && enable) begin
          if (wall_xleft < step) begin
            state_next = ST_RESPAWN;
          end else begin
            xleft_next  = wall_xleft - step;
            passed_next = (wall_xright >= BIRD_X) && (xright_next < BIRD_X);
          end
        end
      end
      ST_RESPAWN: begin
        // A frame tick landing here is intentionally dropped.
        xleft_next   = SCREEN_W;
        topy_next    = Y_MIN + {2'b00, lfsr[5:0]};
        bottomy_next = topy_next + GAP_H;
        state_next   = ST_SCROLL;
      end
      default: state_next = ST_IDLE;
    endcase

    if (restart) begin
      state_next   = ST_IDLE;
      xleft_next   = SCREEN_W;
      topy_next    = TOPY_RESET;
      bottomy_next = TOPY_RESET + GAP_H;
      passed_next  = 1'b0;
    end

    valid_next = (state_next != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      wall_xleft   <= SCREEN_W;
      wall_topy    <= TOPY_RESET;
      wall_bottomy <= TOPY_RESET + GAP_H;
      wall_valid   <= 1'b0;
      passed       <= 1'b0;
    end else begin
      state        <= state_next;
      wall_xleft   <= xleft_next;
      wall_topy    <= topy_next;
      wall_bottomy <= bottomy_next;
      wall_valid   <= valid_next;
      passed       <= passed_next;
    end
  end

endmodule
